// File: rtl/test_vector_checker_pkg.sv
// Shared types and helpers for the on-chip test vector checker.
// The FSM walks FETCH -> APPLY -> SETTLE -> CHECK once per stored vector.
package test_vector_checker_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_APPLY,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE
    } chk_state_t;

    // Width of one stored vector word: {inputs, expected}.
    function automatic int vec_width(input int nin, input int nout);
        return nin + nout;
    endfunction

endpackage

// File: rtl/test_vector_checker_if.sv
// Bundle of run control, status, vector ROM and DUT-side signals of the checker.
// master = checker side, slave = host / ROM / DUT side.
interface test_vector_checker_if import test_vector_checker_pkg::*; #(
    parameter int NIN  = 3,
    parameter int NOUT = 1,
    parameter int AW   = 3
);
    localparam int VW = vec_width(NIN, NOUT);

    logic            start;
    logic [AW:0]     num_vec;
    logic [AW-1:0]   vec_addr;
    logic [VW-1:0]   vec_data;
    logic [NIN-1:0]  dut_in;
    logic [NOUT-1:0] dut_out;
    logic            busy;
    logic            done;
    logic            pass;
    logic [AW:0]     err_count;
    logic            fail_valid;
    logic [AW-1:0]   first_fail;

    modport master (
        input  start, num_vec, vec_data, dut_out,
        output vec_addr, dut_in, busy, done, pass, err_count, fail_valid, first_fail
    );

    modport slave (
        output start, num_vec, vec_data, dut_out,
        input  vec_addr, dut_in, busy, done, pass, err_count, fail_valid, first_fail
    );

endinterface

// File: rtl/test_vector_checker.sv
// Self-checking vector engine: drives stored input patterns onto a combinational DUT,
// compares the settled response against the stored expectation and reports results.
module test_vector_checker import test_vector_checker_pkg::*; #(
    parameter int NIN    = 3,
    parameter int NOUT   = 1,
    parameter int AW     = 3,
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic reset_n,
    test_vector_checker_if.master bus
);
    localparam int VW = vec_width(NIN, NOUT);
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [AW:0] MAX_VEC = {1'b1, {AW{1'b0}}};

    function automatic logic [AW:0] sat_inc(input logic [AW:0] v);
        return (&v) ? v : v + (AW+1)'(1);
    endfunction

    function automatic logic [AW:0] clamp_num(input logic [AW:0] n);
        return (n > MAX_VEC) ? MAX_VEC : n;
    endfunction

    chk_state_t      state, state_nxt;
    logic [AW-1:0]   idx;
    logic [AW:0]     num_q;
    logic [SW-1:0]   settle_cnt;
    logic [NIN-1:0]  dut_in_q;
    logic [NOUT-1:0] exp_q;
    logic [AW:0]     err_q;
    logic            fail_q;
    logic [AW-1:0]   first_q;
    logic            done_q;
    logic            pass_q;
    logic            start_ok;
    logic            last_vec;
    logic            settle_end;
    logic            mismatch;
    logic            busy;

    assign start_ok   = bus.start && (state == ST_IDLE || state == ST_DONE);
    assign last_vec   = ({1'b0, idx} == num_q - (AW+1)'(1));
    assign settle_end = (settle_cnt == SW'(SETTLE - 1));
    // Case inequality so an X/Z response in simulation counts as a failure.
    assign mismatch   = (bus.dut_out !== exp_q);

    always_ff @(posedge clk) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start_ok)
                    state_nxt = (clamp_num(bus.num_vec) == '0) ? ST_DONE : ST_FETCH;
            end
            ST_FETCH: begin
                busy      = 1'b1;
                state_nxt = ST_APPLY;
            end
            ST_APPLY: begin
                busy      = 1'b1;
                state_nxt = ST_SETTLE;
            end
            ST_SETTLE: begin
                busy = 1'b1;
                if (settle_end) state_nxt = ST_CHECK;
            end
            ST_CHECK: begin
                busy      = 1'b1;
                state_nxt = last_vec ? ST_DONE : ST_FETCH;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            idx        <= '0;
            num_q      <= '0;
            settle_cnt <= '0;
            dut_in_q   <= '0;
            exp_q      <= '0;
            err_q      <= '0;
            fail_q     <= 1'b0;
            first_q    <= '0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            // done/pass trail DONE entry by one cycle so a result is flagged only once settled.
            if (start_ok) begin
                idx    <= '0;
                num_q  <= clamp_num(bus.num_vec);
                err_q  <= '0;
                fail_q <= 1'b0;
                first_q <= '0;
                done_q <= 1'b0;
                pass_q <= 1'b0;
            end else if (state == ST_DONE) begin
                done_q <= 1'b1;
                pass_q <= (err_q == '0);
            end

            if (state == ST_APPLY) begin
                dut_in_q <= bus.vec_data[VW-1:NOUT];
                exp_q    <= bus.vec_data[NOUT-1:0];
            end

            settle_cnt <= (state == ST_SETTLE && !settle_end) ? settle_cnt + SW'(1) : '0;

            if (state == ST_CHECK) begin
                if (mismatch) begin
                    err_q <= sat_inc(err_q);
                    if (!fail_q) begin
                        fail_q  <= 1'b1;
                        first_q <= idx;
                    end
                end
                if (!last_vec) idx <= idx + AW'(1);
            end
        end
    end

    assign bus.vec_addr   = idx;
    assign bus.dut_in     = dut_in_q;
    assign bus.busy       = busy;
    assign bus.done       = done_q;
    assign bus.pass       = pass_q;
    assign bus.err_count  = err_q;
    assign bus.fail_valid = fail_q;
    assign bus.first_fail = first_q;

endmodule
